fft_bitrev_reorder: RTL

Reorders the 16-lane, 11-bit block-floating-point samples leaving the CBFP stage from bit-reversed to natural order. It accepts 64-point frames of 4 beats × 16 lanes, one beat per `valid_in`, and stores each frame in one bank of a ping-pong register store. It then streams the frame out as 4 contiguous beats in natural index order. It sits directly downstream of the CBFP stage and consumes its `dout_re`/`dout_im`/`valid_out` bundle unchanged.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_bitrev_bank.sv | 31 +++
 rtl/fft_bitrev_reorder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type, read FSM state type and bit-reverse helper
// for the FFT output reorder stage.
package fft_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned N      = LANES * BEATS;
    localparam int unsigned LOG2N  = 6;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic {
        StIdle,
        StDrain
    } rd_state_e;

    function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] n);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = n[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// One 64-entry re/im register bank: 16-lane write of one beat per cycle,
// full parallel read view of all entries.
module fft_bitrev_bank
    import fft_pkg::*;
(
    input  logic     clk,
    input  logic     i_we,
    input  logic [1:0] i_wbeat,
    input  sample_t  i_wr_re [LANES],
    input  sample_t  i_wr_im [LANES],
    output sample_t  o_rd_re [N],
    output sample_t  o_rd_im [N]
);

    sample_t r_mem_re [N];
    sample_t r_mem_im [N];

    // Contents are deliberately not reset; a frame is always fully written before being read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < int'(LANES); l++) begin
                r_mem_re[{i_wbeat, 4'(l)}] <= i_wr_re[l];
                r_mem_im[{i_wbeat, 4'(l)}] <= i_wr_im[l];
            end
        end
    end

    assign o_rd_re = r_mem_re;
    assign o_rd_im = r_mem_im;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder of 64-point, 16-lane frames using a
// ping-pong register store and a one-frame-at-a-time drain FSM.
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    valid_in,
    input  sample_t din_re [LANES],
    input  sample_t din_im [LANES],
    output sample_t dout_re [LANES],
    output sample_t dout_im [LANES],
    output logic    valid_out,
    output logic    sop,
    output logic    eop
);

    logic [1:0] r_wbeat;
    logic       r_wbank;
    logic       w_rd_req;

    rd_state_e  r_state, w_state_d;
    logic       r_rbank, w_rbank_d;
    logic [1:0] r_rbeat, w_rbeat_d;
    logic       w_out_en;

    sample_t w_ping_re [N];
    sample_t w_ping_im [N];
    sample_t w_pong_re [N];
    sample_t w_pong_im [N];
    sample_t w_sel_re [LANES];
    sample_t w_sel_im [LANES];

    sample_t r_dout_re [LANES];
    sample_t r_dout_im [LANES];
    logic    r_valid, r_sop, r_eop;

    assign w_rd_req = valid_in && (r_wbeat == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wbeat <= '0;
            r_wbank <= 1'b0;
        end else if (valid_in) begin
            r_wbeat <= r_wbeat + 2'd1;
            if (r_wbeat == 2'd3) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    fft_bitrev_bank u_bank_ping (
        .clk     (clk),
        .i_we    (valid_in && !r_wbank),
        .i_wbeat (r_wbeat),
        .i_wr_re (din_re),
        .i_wr_im (din_im),
        .o_rd_re (w_ping_re),
        .o_rd_im (w_ping_im)
    );

    fft_bitrev_bank u_bank_pong (
        .clk     (clk),
        .i_we    (valid_in && r_wbank),
        .i_wbeat (r_wbeat),
        .i_wr_re (din_re),
        .i_wr_im (din_im),
        .o_rd_re (w_pong_re),
        .o_rd_im (w_pong_im)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_rbank <= 1'b0;
            r_rbeat <= '0;
        end else begin
            r_state <= w_state_d;
            r_rbank <= w_rbank_d;
            r_rbeat <= w_rbeat_d;
        end
    end

    // r_wbank still names the bank being completed in the cycle w_rd_req is high.
    always_comb begin
        w_state_d = r_state;
        w_rbank_d = r_rbank;
        w_rbeat_d = r_rbeat;
        w_out_en  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rd_req) begin
                    w_state_d = StDrain;
                    w_rbank_d = r_wbank;
                    w_rbeat_d = '0;
                end
            end
            StDrain: begin
                w_out_en = 1'b1;
                if (r_rbeat == 2'd3) begin
                    if (w_rd_req) begin
                        w_rbank_d = r_wbank;
                        w_rbeat_d = '0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_rbeat_d = r_rbeat + 2'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            w_sel_re[l] = r_rbank ? w_pong_re[bitrev6({r_rbeat, 4'(l)})]
                                  : w_ping_re[bitrev6({r_rbeat, 4'(l)})];
            w_sel_im[l] = r_rbank ? w_pong_im[bitrev6({r_rbeat, 4'(l)})]
                                  : w_ping_im[bitrev6({r_rbeat, 4'(l)})];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                r_dout_re[l] <= '0;
                r_dout_im[l] <= '0;
            end
        end else begin
            r_valid <= w_out_en;
            r_sop   <= w_out_en && (r_rbeat == 2'd0);
            r_eop   <= w_out_en && (r_rbeat == 2'd3);
            if (w_out_en) begin
                r_dout_re <= w_sel_re;
                r_dout_im <= w_sel_im;
            end
        end
    end

    assign dout_re   = r_dout_re;
    assign dout_im   = r_dout_im;
    assign valid_out = r_valid;
    assign sop       = r_sop;
    assign eop       = r_eop;

endmodule
